vram_scanout: RTL and testbench

- Render-side reader for the 24 KiB dual-port VRAM.
- Walks the 256x192, 4 bpp framebuffer (128 bytes/line, 24576 bytes) in raster order and drives the VRAM render port address.
- Unpacks nibbles, scales each source pixel by SCALE in both axes, and emits palette indices aligned with delayed sync/DE.
- Sits between the video timing generator and the palette/DAC stage.

---
 rtl/vram_pkg.sv | 18 +
 rtl/sync_delay.sv | 35 +++
 rtl/vram_scanout.sv | 150 +++++++++++++++
 tb/tb_vram_scanout.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared constants and inter-stage bundles for the VRAM render-side reader.
// Framebuffer is 256x192 at 4 bpp, packed two pixels per byte.
package vram_pkg;

  localparam int VRAM_DEPTH     = 24576;
  localparam int FB_W           = 256;
  localparam int FB_H           = 192;
  localparam int FB_BPP         = 4;
  localparam int BYTES_PER_LINE = 128;
  localparam int ADDR_W         = 15;
  localparam int PIPE_LAT       = 3;

  typedef struct packed {
    logic nib_sel;
    logic in_range;
  } fetch_t;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register used to align timing signals with pixel data.
// Every stage clears on reset.
module sync_delay #(
  parameter int W = 1,
  parameter int D = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr_q [D];
  logic [W-1:0] sr_d [D];

  always_comb begin
    sr_d[0] = d;
    for (int i = 1; i < D; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q[D-1];

endmodule

// File: rtl/vram_scanout.sv
// Raster-order VRAM reader: address generation, nibble unpack and
// pixel replication, with sync/DE delayed to match pixel latency.
module vram_scanout #(
  parameter int H_PIXELS = vram_pkg::FB_W,
  parameter int V_LINES  = vram_pkg::FB_H,
  parameter int SCALE    = 2,
  parameter int ADDR_W   = vram_pkg::ADDR_W
) (
  input  logic              render_clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              win_de,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] render_addr,
  input  logic [7:0]        render_data,
  output logic [3:0]        pix_idx,
  output logic              de_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              frame_done
);
  import vram_pkg::*;

  localparam int PXW = $clog2(H_PIXELS + 1);
  localparam int PYW = $clog2(V_LINES + 1);

  localparam logic [1:0]        SUB_MAX   = 2'(SCALE - 1);
  localparam logic [PXW-1:0]    PX_END    = PXW'(H_PIXELS);
  localparam logic [PYW-1:0]    PY_END    = PYW'(V_LINES);
  localparam logic [PYW-1:0]    PY_LAST   = PYW'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS / 2);

  logic [1:0]        hsub_q, hsub_d;
  logic [1:0]        vsub_q, vsub_d;
  logic [PXW-1:0]    px_q, px_d;
  logic [PYW-1:0]    py_q, py_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              de_q;
  logic              done_q, done_d;
  fetch_t            s1_q, s1_d;
  fetch_t            s2_q;
  logic [3:0]        pix_q, pix_d;
  logic              in_range;
  logic              line_end;
  logic [2:0]        sync_q;

  always_comb begin
    in_range = (px_q != PX_END) && (py_q != PY_END);
    line_end = de_q && !win_de;

    hsub_d = hsub_q;
    vsub_d = vsub_q;
    px_d   = px_q;
    py_d   = py_q;
    base_d = base_q;
    addr_d = addr_q;
    done_d = 1'b0;

    s1_d.nib_sel  = px_q[0];
    s1_d.in_range = win_de && in_range;

    // Out-of-window fetches leave the address where it was.
    if (win_de && in_range) begin
      addr_d = base_q + ADDR_W'(px_q[PXW-1:1]);
    end

    if (frame_start) begin
      hsub_d = '0;
      vsub_d = '0;
      px_d   = '0;
      py_d   = '0;
      base_d = '0;
    end else if (win_de) begin
      if (hsub_q == SUB_MAX) begin
        hsub_d = '0;
        if (px_q != PX_END) begin
          px_d = px_q + PXW'(1);
        end
      end else begin
        hsub_d = hsub_q + 2'd1;
      end
    end else if (line_end) begin
      hsub_d = '0;
      px_d   = '0;
      if (vsub_q == SUB_MAX) begin
        vsub_d = '0;
        done_d = (py_q == PY_LAST);
        if (py_q != PY_END) begin
          py_d   = py_q + PYW'(1);
          base_d = base_q + LINE_STEP;
        end
      end else begin
        vsub_d = vsub_q + 2'd1;
      end
    end

    pix_d = 4'h0;
    if (s2_q.in_range) begin
      pix_d = s2_q.nib_sel ? render_data[3:0] : render_data[7:4];
    end
  end

  always_ff @(posedge render_clk or negedge rst_n) begin
    if (!rst_n) begin
      hsub_q <= '0;
      vsub_q <= '0;
      px_q   <= '0;
      py_q   <= '0;
      base_q <= '0;
      addr_q <= '0;
      de_q   <= 1'b0;
      done_q <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      pix_q  <= '0;
    end else begin
      hsub_q <= hsub_d;
      vsub_q <= vsub_d;
      px_q   <= px_d;
      py_q   <= py_d;
      base_q <= base_d;
      addr_q <= addr_d;
      de_q   <= win_de;
      done_q <= done_d;
      s1_q   <= s1_d;
      s2_q   <= s1_q;
      pix_q  <= pix_d;
    end
  end

  sync_delay #(
    .W (3),
    .D (PIPE_LAT)
  ) u_sync (
    .clk   (render_clk),
    .rst_n (rst_n),
    .d     ({win_de, hsync_in, vsync_in}),
    .q     (sync_q)
  );

  assign render_addr = addr_q;
  assign pix_idx     = pix_q;
  assign frame_done  = done_q;
  assign de_out      = sync_q[2];
  assign hsync_out   = sync_q[1];
  assign vsync_out   = sync_q[0];

endmodule

// File: tb/tb_vram_scanout.sv
// Self-checking bench for vram_scanout: per-cycle scoreboard of
// address/done and pixel/sync streams against a raster formula model.
module tb_vram_scanout;

  localparam int H     = 256;
  localparam int V     = 192;
  localparam int SCALE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_start = 1'b0;
  logic        win_de = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [14:0] render_addr;
  logic [7:0]  render_data;
  logic [3:0]  pix_idx;
  logic        de_out, hsync_out, vsync_out, frame_done;

  vram_scanout dut (
    .render_clk  (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .win_de      (win_de),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .render_addr (render_addr),
    .render_data (render_data),
    .pix_idx     (pix_idx),
    .de_out      (de_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [32768];
  always @(posedge clk) render_data <= mem[render_addr];

  typedef struct packed {
    logic [3:0] pix;
    logic       de;
    logic       hs;
    logic       vs;
  } pix_rec_t;

  typedef struct packed {
    logic [14:0] addr;
    logic        done;
  } adr_rec_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic ehs;
    logic evs;
  } vec_t;

  pix_rec_t    pq[$];
  adr_rec_t    aq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          wl, c;
  logic        prev_de;
  logic [14:0] m_addr;
  int          done_cnt = 0;

  always @(negedge clk) if (frame_done) done_cnt++;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %h exp %h", name, $time, got, exp);
    end
  endtask

  task automatic step(input logic fs, input logic de,
                      input logic hs, input logic vs);
    pix_rec_t pr;
    adr_rec_t ar;
    int spx, spy, a;
    logic [7:0] b;
    pix_rec_t pg;
    adr_rec_t ag;
    frame_start = fs;
    win_de      = de;
    hsync_in    = hs;
    vsync_in    = vs;
    pr = '0;
    ar = '0;
    pr.de = de;
    pr.hs = hs;
    pr.vs = vs;
    if (de) begin
      spx = c / SCALE;
      spy = wl / SCALE;
      if (spx < H && spy < V) begin
        a = spy * (H / 2) + spx / 2;
        m_addr = 15'(a);
        b = mem[a];
        pr.pix = (spx % 2 == 1) ? b[3:0] : b[7:4];
      end
    end
    if (fs) begin
      wl = 0;
      c  = 0;
    end else if (de) begin
      c++;
    end else if (prev_de) begin
      ar.done = (wl == SCALE * V - 1);
      wl++;
      c = 0;
    end
    prev_de = de;
    ar.addr = m_addr;
    pq.push_back(pr);
    aq.push_back(ar);
    @(posedge clk);
    #1;
    ag = aq.pop_front();
    chk("addr_done", {16'h0, render_addr, frame_done}, {16'h0, ag});
    if (pq.size() >= 3) begin
      pg = pq.pop_front();
      chk("pix_sync", {25'h0, pix_idx, de_out, hsync_out, vsync_out},
          {25'h0, pg});
    end
  endtask

  task automatic do_reset();
    frame_start = 1'b0;
    win_de      = 1'b0;
    hsync_in    = 1'b0;
    vsync_in    = 1'b0;
    rst_n       = 1'b0;
    #1;
    chk("rst_addr", {17'h0, render_addr}, 0);
    chk("rst_pix", {28'h0, pix_idx}, 0);
    chk("rst_de", {31'h0, de_out}, 0);
    chk("rst_hs", {31'h0, hsync_out}, 0);
    chk("rst_vs", {31'h0, vsync_out}, 0);
    chk("rst_done", {31'h0, frame_done}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pq.delete();
    aq.delete();
    pq.push_back('0);
    pq.push_back('0);
    wl = 0;
    c = 0;
    prev_de = 1'b0;
    m_addr = '0;
  endtask

  task automatic line(input int n, input int gap);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < gap; i++) step(1'b0, 1'b0, i == 0, 1'b0);
  endtask

  task automatic newframe();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [8];
    int   d0;
    tbl[0] = '{hs: 1, vs: 0, ehs: 0, evs: 0};
    tbl[1] = '{hs: 0, vs: 1, ehs: 0, evs: 0};
    tbl[2] = '{hs: 1, vs: 1, ehs: 1, evs: 0};
    tbl[3] = '{hs: 1, vs: 0, ehs: 0, evs: 1};
    tbl[4] = '{hs: 0, vs: 0, ehs: 1, evs: 1};
    tbl[5] = '{hs: 0, vs: 0, ehs: 1, evs: 0};
    tbl[6] = '{hs: 0, vs: 0, ehs: 0, evs: 0};
    tbl[7] = '{hs: 0, vs: 0, ehs: 0, evs: 0};

    for (int i = 0; i < 32768; i++) begin
      mem[i] = (i < 24576) ? 8'(i * 7 + 8'hA5) : 8'h00;
    end

    #2;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, tbl[i].hs, tbl[i].vs);
      chk("tbl_sync", {30'h0, hsync_out, vsync_out},
          {30'h0, tbl[i].ehs, tbl[i].evs});
    end

    // first line byte0=A5, then line repeat and next source line
    newframe();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("l0_first_addr", {17'h0, render_addr}, 0);
    line(511, 4);
    line(512, 4);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("l2_first_addr", {17'h0, render_addr}, 128);
    line(511, 4);

    // horizontal overrun
    newframe();
    line(520, 0);
    chk("h_ovr_hold", {17'h0, render_addr}, 127);
    line(0, 4);

    // frame_start mid-line at px=40 on line 10
    newframe();
    repeat (10) line(4, 1);
    line(80, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("fs_mid_prev", {17'h0, render_addr}, 660);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("fs_addr0", {17'h0, render_addr}, 0);
    line(19, 3);

    // full frame with short middle lines, then one line past the end
    newframe();
    d0 = done_cnt;
    repeat (382) line(4, 1);
    line(512, 3);
    line(512, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("frame_done", {31'h0, frame_done}, 1);
    chk("last_addr", {17'h0, render_addr}, 24575);
    line(0, 3);
    chk("done_once", done_cnt, d0 + 1);
    line(512, 3);
    chk("v_ovr_hold", {17'h0, render_addr}, 24575);
    chk("done_still_once", done_cnt, d0 + 1);

    // async reset in the middle of a line
    newframe();
    line(50, 0);
    do_reset();
    newframe();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_restart", {17'h0, render_addr}, 0);
    line(15, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
